trellis_data_fifo: RTL

//  Rate-decoupling buffer between STC frame alignment and the trellis decoder. Stores each

---
 rtl/trellis_data_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/trellis_data_fifo.sv
// Rate-decoupling FIFO between STC frame alignment and the trellis decoder, with
// registered almost-full/empty flags. Optional status outputs under TD_FIFO_STATUS_EN.
module trellis_data_fifo #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clkEn,
  input  logic                     flush,
  input  logic                     startOfTrellis,
  input  logic                     wrEn,
  input  logic                     interpolate,
  input  logic signed [17:0]       dinReal0,
  input  logic signed [17:0]       dinImag0,
  input  logic signed [17:0]       dinReal1,
  input  logic signed [17:0]       dinImag1,
  input  logic                     rdEn,
  output logic signed [17:0]       doutReal0,
  output logic signed [17:0]       doutImag0,
  output logic signed [17:0]       doutReal1,
  output logic signed [17:0]       doutImag1,
  output logic                     doutInterp,
  output logic                     doutSot,
  output logic                     doutValid,
  output logic                     tdFifoFull,
  output logic                     empty,
  output logic [ADDR_WIDTH:0]      level
`ifdef TD_FIFO_STATUS_EN
  ,
  output logic                     overflow,
  output logic                     underflow,
  output logic [15:0]              dropCount
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_TH = (ADDR_WIDTH + 1)'(DEPTH - FULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // Word layout: {sot, interp, real0, imag0, real1, imag1}
  logic [73:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  sot_pend_q, sot_pend_d;
  logic                  stg_valid_q, stg_valid_d;
  logic [73:0]           stg_word_q, stg_word_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [73:0]           dout_word_q, dout_word_d;
  logic [73:0]           wr_word;
  logic                  wr_acc, rd_acc;
`ifdef TD_FIFO_STATUS_EN
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [15:0]           drop_q, drop_d;
`endif

  always_comb begin
    wr_acc       = wrEn && (level_q != DEPTH_L) && !flush;
    rd_acc       = rdEn && (level_q != '0) && !flush;
    wr_word      = {startOfTrellis | sot_pend_q, interpolate, dinReal0, dinImag0, dinReal1, dinImag1};
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    empty_d      = empty_q;
    full_d       = full_q;
    sot_pend_d   = sot_pend_q;
    stg_valid_d  = stg_valid_q;
    stg_word_d   = stg_word_q;
    dout_valid_d = dout_valid_q;
    dout_word_d  = dout_word_q;
`ifdef TD_FIFO_STATUS_EN
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    drop_d       = drop_q;
`endif
    if (clkEn) begin
      if (flush) begin
        // Flush clears state like reset but leaves the output data bus untouched.
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        level_d      = '0;
        empty_d      = 1'b1;
        full_d       = 1'b0;
        sot_pend_d   = 1'b0;
        stg_valid_d  = 1'b0;
        dout_valid_d = 1'b0;
`ifdef TD_FIFO_STATUS_EN
        ovf_d        = 1'b0;
        udf_d        = 1'b0;
        drop_d       = '0;
`endif
      end else begin
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
          2'b10:   level_d = level_q + LVL_ONE;
          2'b01:   level_d = level_q - LVL_ONE;
          default: level_d = level_q;
        endcase
        if (wr_acc)              sot_pend_d = 1'b0;
        else if (startOfTrellis) sot_pend_d = 1'b1;
        // Two-stage read: memory into staging register, then onto the output bus.
        stg_valid_d  = rd_acc;
        if (rd_acc) stg_word_d = mem_q[rd_ptr_q];
        dout_valid_d = stg_valid_q;
        if (stg_valid_q) dout_word_d = stg_word_q;
        empty_d      = (level_d == '0);
        full_d       = (level_d >= FULL_TH);
`ifdef TD_FIFO_STATUS_EN
        if (wrEn && (level_q == DEPTH_L)) begin
          ovf_d = 1'b1;
          if (drop_q != '1) drop_d = drop_q + 16'd1;
        end
        if (rdEn && (level_q == '0)) udf_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      sot_pend_q   <= 1'b0;
      stg_valid_q  <= 1'b0;
      stg_word_q   <= '0;
      dout_valid_q <= 1'b0;
      dout_word_q  <= '0;
`ifdef TD_FIFO_STATUS_EN
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      drop_q       <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      sot_pend_q   <= sot_pend_d;
      stg_valid_q  <= stg_valid_d;
      stg_word_q   <= stg_word_d;
      dout_valid_q <= dout_valid_d;
      dout_word_q  <= dout_word_d;
`ifdef TD_FIFO_STATUS_EN
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      drop_q       <= drop_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && clkEn && wr_acc) mem_q[wr_ptr_q] <= wr_word;
  end

  assign {doutSot, doutInterp, doutReal0, doutImag0, doutReal1, doutImag1} = dout_word_q;
  assign doutValid  = dout_valid_q;
  assign tdFifoFull = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
`ifdef TD_FIFO_STATUS_EN
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign dropCount  = drop_q;
`endif

endmodule
